// File: rtl/coreriscv_axi4_tl_pkg.sv
// coreriscv_axi4_tl_pkg: TileLink Acquire field widths, constants and packed beat type
package coreriscv_axi4_tl_pkg;
  localparam int HDR_W = 2;
  localparam int ADDR_BLOCK_W = 26;
  localparam int XACT_ID_W = 1;
  localparam int ADDR_BEAT_W = 3;
  localparam int BUILTIN_W = 1;
  localparam int A_TYPE_W = 3;
  localparam int UNION_W = 12;
  localparam int DATA_W = 64;
  localparam logic [A_TYPE_W-1:0] ACQ_PUT_BLOCK = 3'h3;
  localparam int BEATS_PER_BLOCK = 8;
  typedef struct packed {
    logic [HDR_W-1:0] header_src;
    logic [HDR_W-1:0] header_dst;
    logic [ADDR_BLOCK_W-1:0] addr_block;
    logic [XACT_ID_W-1:0] client_xact_id;
    logic [ADDR_BEAT_W-1:0] addr_beat;
    logic [BUILTIN_W-1:0] is_builtin_type;
    logic [A_TYPE_W-1:0] a_type;
    logic [UNION_W-1:0] union_bits;
    logic [DATA_W-1:0] data;
  } acq_beat_t;
  function automatic logic is_multi(acq_beat_t b);
    return b.is_builtin_type[0] && b.a_type == ACQ_PUT_BLOCK;
  endfunction
endpackage

// File: rtl/coreriscv_axi4_acquire_fifo_ram.sv
// coreriscv_axi4_acquire_fifo_ram: DEPTH x Acquire-beat storage, synchronous write, asynchronous read
module coreriscv_axi4_acquire_fifo_ram
  import coreriscv_axi4_tl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we_i,
  input  logic [AW-1:0] waddr_i,
  input  acq_beat_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output acq_beat_t rdata_o
);
  acq_beat_t mem [DEPTH];
  always_ff @(posedge clk) if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/coreriscv_axi4_acquire_saf_queue.sv
// coreriscv_axi4_acquire_saf_queue: store-and-forward Acquire FIFO releasing only complete messages
module coreriscv_axi4_acquire_saf_queue
  import coreriscv_axi4_tl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  output logic io_in_ready,
  input  logic io_in_valid,
  input  logic [1:0] io_in_bits_header_src,
  input  logic [1:0] io_in_bits_header_dst,
  input  logic [25:0] io_in_bits_payload_addr_block,
  input  logic [0:0] io_in_bits_payload_client_xact_id,
  input  logic [2:0] io_in_bits_payload_addr_beat,
  input  logic [0:0] io_in_bits_payload_is_builtin_type,
  input  logic [2:0] io_in_bits_payload_a_type,
  input  logic [11:0] io_in_bits_payload_union,
  input  logic [63:0] io_in_bits_payload_data,
  input  logic io_out_ready,
  output logic io_out_valid,
  output logic [1:0] io_out_bits_header_src,
  output logic [1:0] io_out_bits_header_dst,
  output logic [25:0] io_out_bits_payload_addr_block,
  output logic [0:0] io_out_bits_payload_client_xact_id,
  output logic [2:0] io_out_bits_payload_addr_beat,
  output logic [0:0] io_out_bits_payload_is_builtin_type,
  output logic [2:0] io_out_bits_payload_a_type,
  output logic [11:0] io_out_bits_payload_union,
  output logic [63:0] io_out_bits_payload_data,
  output logic [CNT_W-1:0] io_count,
  output logic [CNT_W-1:0] io_msgs
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_BLOCK - 1);
  if (DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 8");
  end
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, msgs_q, msgs_d;
  logic [2:0] in_beat_q, in_beat_d, out_beat_q, out_beat_d;
  logic enq, deq, in_multi, out_multi, in_last, out_last;
  acq_beat_t in_w, head_w;
  assign in_w = '{
    header_src: io_in_bits_header_src,
    header_dst: io_in_bits_header_dst,
    addr_block: io_in_bits_payload_addr_block,
    client_xact_id: io_in_bits_payload_client_xact_id,
    addr_beat: io_in_bits_payload_addr_beat,
    is_builtin_type: io_in_bits_payload_is_builtin_type,
    a_type: io_in_bits_payload_a_type,
    union_bits: io_in_bits_payload_union,
    data: io_in_bits_payload_data
  };
  always_comb begin
    io_in_ready = count_q != CNT_W'(DEPTH);
    io_out_valid = count_q != '0 && msgs_q != '0;
    enq = io_in_valid && io_in_ready;
    deq = io_out_valid && io_out_ready;
    in_multi = is_multi(in_w);
    out_multi = is_multi(head_w);
    in_last = !in_multi || in_beat_q == LAST_BEAT;
    out_last = !out_multi || out_beat_q == LAST_BEAT;
    wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
    in_beat_d = enq && in_multi ? (in_last ? 3'd0 : in_beat_q + 3'd1) : in_beat_q;
    out_beat_d = deq && out_multi ? (out_last ? 3'd0 : out_beat_q + 3'd1) : out_beat_q;
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    msgs_d = msgs_q + CNT_W'(enq && in_last) - CNT_W'(deq && out_last);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      msgs_q <= '0;
      in_beat_q <= '0;
      out_beat_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      msgs_q <= msgs_d;
      in_beat_q <= in_beat_d;
      out_beat_q <= out_beat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(io_in_valid && count_q == CNT_W'(DEPTH) && enq));
      assert (msgs_q <= count_q);
      assert (!(enq && in_multi) || io_in_bits_payload_addr_beat == in_beat_q);
    end
  end
  coreriscv_axi4_acquire_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we_i(enq),
    .waddr_i(wr_ptr_q),
    .wdata_i(in_w),
    .raddr_i(rd_ptr_q),
    .rdata_o(head_w)
  );
  assign io_out_bits_header_src = head_w.header_src;
  assign io_out_bits_header_dst = head_w.header_dst;
  assign io_out_bits_payload_addr_block = head_w.addr_block;
  assign io_out_bits_payload_client_xact_id = head_w.client_xact_id;
  assign io_out_bits_payload_addr_beat = head_w.addr_beat;
  assign io_out_bits_payload_is_builtin_type = head_w.is_builtin_type;
  assign io_out_bits_payload_a_type = head_w.a_type;
  assign io_out_bits_payload_union = head_w.union_bits;
  assign io_out_bits_payload_data = head_w.data;
  assign io_count = count_q;
  assign io_msgs = msgs_q;
endmodule

// File: tb/tb_coreriscv_axi4_acquire_saf_queue.sv
// tb_coreriscv_axi4_acquire_saf_queue: randomized scoreboard bench for the store-and-forward Acquire queue
module tb_coreriscv_axi4_acquire_saf_queue;
  import coreriscv_axi4_tl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic io_in_ready, io_in_valid, io_out_ready, io_out_valid;
  logic [1:0] o_src, o_dst;
  logic [25:0] o_addr_block;
  logic [0:0] o_xact, o_builtin;
  logic [2:0] o_addr_beat, o_a_type;
  logic [11:0] o_union;
  logic [63:0] o_data;
  logic [4:0] io_count, io_msgs;
  acq_beat_t in_b, out_b;
  acq_beat_t src[$], partial[$], done[$];
  int mlen[$];
  int p_valid, p_ready;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  assign out_b = {o_src, o_dst, o_addr_block, o_xact, o_addr_beat, o_builtin, o_a_type, o_union, o_data};
  coreriscv_axi4_acquire_saf_queue dut (
    .clk(clk),
    .reset(reset),
    .io_in_ready(io_in_ready),
    .io_in_valid(io_in_valid),
    .io_in_bits_header_src(in_b.header_src),
    .io_in_bits_header_dst(in_b.header_dst),
    .io_in_bits_payload_addr_block(in_b.addr_block),
    .io_in_bits_payload_client_xact_id(in_b.client_xact_id),
    .io_in_bits_payload_addr_beat(in_b.addr_beat),
    .io_in_bits_payload_is_builtin_type(in_b.is_builtin_type),
    .io_in_bits_payload_a_type(in_b.a_type),
    .io_in_bits_payload_union(in_b.union_bits),
    .io_in_bits_payload_data(in_b.data),
    .io_out_ready(io_out_ready),
    .io_out_valid(io_out_valid),
    .io_out_bits_header_src(o_src),
    .io_out_bits_header_dst(o_dst),
    .io_out_bits_payload_addr_block(o_addr_block),
    .io_out_bits_payload_client_xact_id(o_xact),
    .io_out_bits_payload_addr_beat(o_addr_beat),
    .io_out_bits_payload_is_builtin_type(o_builtin),
    .io_out_bits_payload_a_type(o_a_type),
    .io_out_bits_payload_union(o_union),
    .io_out_bits_payload_data(o_data),
    .io_count(io_count),
    .io_msgs(io_msgs)
  );
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int msg_len(acq_beat_t b);
    return (b.is_builtin_type == 1'b1 && b.a_type == 3'h3) ? 8 : 1;
  endfunction
  function automatic int model_count();
    return done.size() + partial.size();
  endfunction
  task automatic add_single(input logic builtin, input logic [2:0] a_type, input logic [25:0] addr, input logic [63:0] data);
    acq_beat_t b;
    b.header_src = 2'($urandom);
    b.header_dst = 2'($urandom);
    b.addr_block = addr;
    b.client_xact_id = 1'($urandom);
    b.addr_beat = 3'($urandom);
    b.is_builtin_type = builtin;
    b.a_type = (builtin && a_type == 3'h3) ? 3'h1 : a_type;
    b.union_bits = 12'($urandom);
    b.data = data;
    src.push_back(b);
  endtask
  task automatic add_put(input logic [25:0] addr, input logic [63:0] base);
    acq_beat_t b;
    b.header_src = 2'($urandom);
    b.header_dst = 2'($urandom);
    b.client_xact_id = 1'($urandom);
    b.union_bits = 12'($urandom);
    b.addr_block = addr;
    b.is_builtin_type = 1'b1;
    b.a_type = 3'h3;
    for (int i = 0; i < 8; i++) begin
      b.addr_beat = 3'(i);
      b.data = base + 64'(i);
      src.push_back(b);
    end
  endtask
  task automatic step();
    bit eq, dq;
    @(posedge clk);
    #1;
    check_eq("in_ready", io_in_ready, model_count() < 16);
    check_eq("out_valid", io_out_valid, mlen.size() > 0);
    check_eq("count", io_count, model_count());
    check_eq("msgs", io_msgs, mlen.size());
    if (mlen.size() > 0) check_eq("head", out_b, done[0]);
    io_in_valid = src.size() > 0 && $urandom_range(99) < p_valid;
    in_b = src.size() > 0 ? src[0] : '0;
    io_out_ready = $urandom_range(99) < p_ready;
    eq = io_in_valid && model_count() < 16;
    dq = io_out_ready && mlen.size() > 0;
    if (dq) begin
      void'(done.pop_front());
      mlen[0] = mlen[0] - 1;
      if (mlen[0] == 0) void'(mlen.pop_front());
    end
    if (eq) begin
      partial.push_back(src.pop_front());
      if (partial.size() == msg_len(partial[0])) begin
        mlen.push_back(partial.size());
        foreach (partial[i]) done.push_back(partial[i]);
        partial.delete();
      end
    end
  endtask
  task automatic run_until_idle(input int bound);
    int k = 0;
    while ((src.size() > 0 || model_count() > 0) && k < bound) begin
      step();
      k++;
    end
    step();
    check_eq("drain", src.size() + model_count(), 0);
  endtask
  initial begin
    io_in_valid = 1'b0;
    io_out_ready = 1'b0;
    in_b = '0;
    p_valid = 100;
    p_ready = 100;
    #11;
    check_eq("rst_in_ready", io_in_ready, 1'b1);
    check_eq("rst_out_valid", io_out_valid, 1'b0);
    check_eq("rst_count", io_count, 0);
    check_eq("rst_msgs", io_msgs, 0);
    reset = 1'b0;
    add_single(1'b1, 3'h0, 26'h123, 64'hdead_beef_0123_4567);
    run_until_idle(50);
    add_put(26'h2aa, 64'hA0);
    run_until_idle(50);
    p_ready = 0;
    for (int i = 0; i < 20; i++) add_single(1'($urandom), 3'($urandom), 26'(i), {$urandom, $urandom});
    repeat (22) step();
    check_eq("full_count", io_count, 16);
    check_eq("full_ready", io_in_ready, 1'b0);
    p_ready = 100;
    run_until_idle(100);
    p_valid = 70;
    p_ready = 50;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(2) == 0) add_put(26'($urandom), {$urandom, $urandom});
      else add_single(1'($urandom), 3'($urandom), 26'($urandom), {$urandom, $urandom});
    end
    run_until_idle(3000);
    p_valid = 100;
    p_ready = 100;
    add_put(26'h155, 64'hB0);
    repeat (5) step();
    @(posedge clk);
    #1;
    check_eq("pre_reset_count", io_count, 5);
    #1;
    reset = 1'b1;
    io_in_valid = 1'b0;
    #1;
    check_eq("mid_rst_count", io_count, 0);
    check_eq("mid_rst_valid", io_out_valid, 1'b0);
    check_eq("mid_rst_msgs", io_msgs, 0);
    src.delete();
    partial.delete();
    done.delete();
    mlen.delete();
    #2;
    reset = 1'b0;
    add_single(1'b0, 3'h2, 26'h3c3, 64'h1111_2222_3333_4444);
    add_put(26'h0f0, 64'hC0);
    run_until_idle(100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/coreriscv_axi4_acquire_saf_queue.md
Name: coreriscv_axi4_acquire_saf_queue

Overview:
Store-and-forward buffer sitting directly downstream of the 4-input locking round-robin Acquire arbiter, feeding the TileLink-to-AXI4 converter.
- Accepts the arbiter's output beats (header + Acquire payload) and holds them in a FIFO.
- Presents a message downstream only once all of its beats are buffered: 8 beats for a builtin putBlock (a_type 3), 1 beat for anything else.
- The converter can therefore issue AW/W without stalling mid-burst.

Parameters:
- DEPTH, 16, FIFO entries (beats). Power of 2, minimum 8; elaboration error otherwise.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy and message counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- io_in_ready  out  1  beat accepted when io_in_valid & io_in_ready.
- io_in_valid  in  1  beat offered by the arbiter.
- io_in_bits_header_src / _dst  in  2 each  network header.
- io_in_bits_payload_addr_block  in  26
- io_in_bits_payload_client_xact_id  in  1
- io_in_bits_payload_addr_beat  in  3
- io_in_bits_payload_is_builtin_type  in  1
- io_in_bits_payload_a_type  in  3
- io_in_bits_payload_union  in  12
- io_in_bits_payload_data  in  64
- io_out_ready  in  1  converter accepts the head beat.
- io_out_valid  out  1  head beat valid and its message is complete.
- io_out_bits_*  out  same widths as io_in_bits_*  head-beat fields.
- io_count  out  CNT_W  beats currently stored.
- io_msgs  out  CNT_W  complete messages currently stored.

Behaviour:
- Reset values:
  - wr_ptr, rd_ptr, count, msgs, in_beat, out_beat all 0.
  - io_in_ready=1, io_out_valid=0, io_count=0, io_msgs=0.
  - Storage contents are not reset; io_out_bits are don't-care while io_out_valid=0.
- Multibeat test: multi = is_builtin_type & (a_type==3'h3). Evaluated on the in-side beat for enqueue and on the head beat for dequeue.
- Enqueue:
  - io_in_ready = (count != DEPTH). No combinational path from io_out_ready.
  - On enq, write entry at wr_ptr, then wr_ptr+1 (wraps mod DEPTH).
  - Single-beat message: in_last=1.
  - Multibeat message: in_beat increments 0..7; in_last=1 when in_beat==7, and in_beat wraps to 0.
- Dequeue:
  - io_out_valid = (count!=0) & (msgs!=0). Head data is read combinationally from entry rd_ptr.
  - deq = io_out_valid & io_out_ready; rd_ptr advances on deq.
  - out_last is computed with out_beat by the same rule as in_last.
- Counters:
  - count += enq - deq.
  - msgs += (enq & in_last) - (deq & out_last).
  - Simultaneous enq and deq: count unchanged. If both are last beats, msgs is unchanged.
- Latency:
  - Single-beat message enqueued in cycle N: io_out_valid=1 in cycle N+1.
  - putBlock whose beat 7 is enqueued in cycle N: io_out_valid=1 in cycle N+1, never earlier.
  - Once msgs>0, beats of the head message stream back-to-back at one per cycle while io_out_ready=1.
- Full: with count==DEPTH, io_in_ready=0. Because DEPTH>=8, a partially buffered burst can always complete once earlier messages drain, so there is no deadlock.
- Empty: count==0 forces io_out_valid=0 regardless of msgs (msgs is 0 in that state by construction).
- in_beat and out_beat count independently; interleaving is impossible because the upstream arbiter locks for the whole burst.
- Assertions (simulation only):
  - No enq when io_in_ready=0.
  - msgs <= count.
  - A multibeat beat's addr_beat equals in_beat.
- Reset asserted mid-burst: all state is cleared asynchronously. Partial and complete buffered messages are discarded. No output beat may appear before a fresh complete message arrives.

Decomposition:
- Shared package coreriscv_axi4_tl_pkg:
  - Field width constants (2/2/26/1/3/1/3/12/64).
  - ACQ_PUT_BLOCK=3'h3.
  - BEATS_PER_BLOCK=8.
  - Packed Acquire beat typedef, 114 bits.
- Sub-module coreriscv_axi4_acquire_fifo_ram:
  - DEPTH x 114-bit register array.
  - Synchronous write, asynchronous read.
- Top level holds the pointers, counters and the beat-tracking logic.

Test Plan:
- Single-beat Get (builtin=1, a_type=0, addr_block=0x123) in cycle 1 -> io_out_valid=1 in cycle 2 with identical fields; io_msgs 0->1->0 after deq.
- putBlock beats 0..7, data=0xA0..0xA7, with io_out_ready=1 -> io_out_valid stays 0 through beat 7's enqueue cycle, rises the next cycle, then 8 consecutive beats 0xA0..0xA7 are output.
- Fill with 16 single-beat messages, io_out_ready=0 -> io_count=16, io_in_ready=0; release io_out_ready -> 16 beats in FIFO order, io_in_ready=1 after the first deq.
- Simultaneous enq of a single-beat message and deq of a single-beat head -> io_count and io_msgs unchanged for the cycle.
- Pointer wrap: 40 mixed messages (single and putBlock) with random io_out_ready -> output sequence matches the scoreboard, with no valid on incomplete bursts.
- Assert reset after beat 4 of a putBlock -> io_count=0, io_out_valid=0 immediately; a following single-beat message is output normally and in_beat restarts at 0.
